// File: rtl/fa_pipe_addsub_if.sv
// Operand/result handshake bundle for fa_pipe_addsub: valid/ready in, valid/ready out.
interface fa_pipe_addsub_if #(
   parameter int unsigned N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         mode;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] s;
   logic         cout;
   logic         ovf;

   modport master (
      output in_valid, a, b, cin, mode, out_ready,
      input  in_ready, out_valid, s, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, mode, out_ready,
      output in_ready, out_valid, s, cout, ovf
   );
endinterface

// File: rtl/fa_pipe_addsub.sv
// Carry-chunked pipelined N-bit adder/subtractor; stage k resolves chunk k from the
// registered carry of stage k-1, with one global stall enable driven by the output side.
module fa_pipe_addsub #(
   parameter int unsigned N      = 32,
   parameter int unsigned STAGES = 4
) (
   input logic             clk,
   input logic             rst_n,
   fa_pipe_addsub_if.slave bus
);
   localparam int unsigned W = N / STAGES;

   logic [N-1:0]        a_q   [STAGES];
   logic [N-1:0]        a_d   [STAGES];
   logic [N-1:0]        b_q   [STAGES];
   logic [N-1:0]        b_d   [STAGES];
   logic [N-1:0]        sum_q [STAGES];
   logic [N-1:0]        sum_d [STAGES];
   logic [STAGES-1:0]   c_q,   c_d;
   logic [STAGES-1:0]   vld_q, vld_d;
   logic                ovf_q, ovf_d;
   logic                en;

   logic [N-1:0] a_in, b_in, sum_in;
   logic         c_in, v_in;
   logic [W:0]   chunk;

   // Whole pipe advances together; the output register frees up when consumed.
   assign en = !vld_q[STAGES-1] || bus.out_ready;

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      sum_d  = sum_q;
      c_d    = c_q;
      vld_d  = vld_q;
      ovf_d  = ovf_q;
      a_in   = '0;
      b_in   = '0;
      sum_in = '0;
      c_in   = 1'b0;
      v_in   = 1'b0;
      chunk  = '0;
      if (en) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            if (k == 0) begin
               a_in   = bus.a;
               b_in   = bus.mode ? ~bus.b : bus.b;
               sum_in = '0;
               c_in   = bus.mode | bus.cin;
               v_in   = bus.in_valid;
            end else begin
               a_in   = a_q[(k == 0) ? 0 : k-1];
               b_in   = b_q[(k == 0) ? 0 : k-1];
               sum_in = sum_q[(k == 0) ? 0 : k-1];
               c_in   = c_q[(k == 0) ? 0 : k-1];
               v_in   = vld_q[(k == 0) ? 0 : k-1];
            end
            chunk = (W+1)'(a_in[k*W +: W]) + (W+1)'(b_in[k*W +: W]) + (W+1)'(c_in);
            sum_d[k]            = sum_in;
            sum_d[k][k*W +: W]  = chunk[W-1:0];
            // Consumed operand chunks are dropped; only the upper part travels on.
            a_d[k]              = a_in;
            a_d[k][k*W +: W]    = '0;
            b_d[k]              = b_in;
            b_d[k][k*W +: W]    = '0;
            c_d[k]              = chunk[W];
            vld_d[k]            = v_in;
            if (k == int'(STAGES) - 1) begin
               // Carry into the MSB recovered from the MSB sum bit and its operands.
               ovf_d = chunk[W] ^ (a_in[N-1] ^ b_in[N-1] ^ chunk[W-1]);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
         c_q   <= '0;
         vld_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         sum_q <= sum_d;
         c_q   <= c_d;
         vld_q <= vld_d;
         ovf_q <= ovf_d;
      end
   end

   assign bus.in_ready  = en;
   assign bus.out_valid = vld_q[STAGES-1];
   assign bus.s         = sum_q[STAGES-1];
   assign bus.cout      = c_q[STAGES-1];
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_fa_pipe_addsub.sv
// Directed bench for fa_pipe_addsub in three shapes: 32/4, 8/1 and 16/16.
module tb_fa_pipe_addsub;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   fa_pipe_addsub_if #(.N(32)) i32 ();
   fa_pipe_addsub_if #(.N(8))  i8 ();
   fa_pipe_addsub_if #(.N(16)) i16 ();

   fa_pipe_addsub #(.N(32), .STAGES(4))  u_dut32 (.clk(clk), .rst_n(rst_n), .bus(i32));
   fa_pipe_addsub #(.N(8),  .STAGES(1))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(i8));
   fa_pipe_addsub #(.N(16), .STAGES(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int cfg, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic mode);
      case (cfg)
         0: begin i32.in_valid = v; i32.a = a;        i32.b = b;        i32.cin = cin; i32.mode = mode; end
         1: begin i8.in_valid  = v; i8.a  = a[7:0];   i8.b  = b[7:0];   i8.cin  = cin; i8.mode  = mode; end
         default: begin i16.in_valid = v; i16.a = a[15:0]; i16.b = b[15:0]; i16.cin = cin; i16.mode = mode; end
      endcase
   endtask

   task automatic sample(input int cfg, output logic ov, output logic [31:0] s,
                         output logic co, output logic of);
      case (cfg)
         0: begin ov = i32.out_valid; s = i32.s;             co = i32.cout; of = i32.ovf; end
         1: begin ov = i8.out_valid;  s = {24'd0, i8.s};     co = i8.cout;  of = i8.ovf;  end
         default: begin ov = i16.out_valid; s = {16'd0, i16.s}; co = i16.cout; of = i16.ovf; end
      endcase
   endtask

   // One operation on an idle pipe: check latency and all result fields.
   task automatic run_op(input int cfg, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic mode, input logic [31:0] exp_s,
                         input logic exp_c, input logic exp_o, input int exp_lat, input string tag);
      logic ov, co, of;
      logic [31:0] s;
      int lat;
      @(negedge clk);
      drive(cfg, 1'b1, a, b, cin, mode);
      @(posedge clk);
      #1;
      drive(cfg, 1'b0, '0, '0, 1'b0, 1'b0);
      lat = 1;
      sample(cfg, ov, s, co, of);
      while (!ov && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         sample(cfg, ov, s, co, of);
      end
      chk({tag, "_lat"},  64'(lat),  64'(exp_lat));
      chk({tag, "_s"},    64'(s),    64'(exp_s));
      chk({tag, "_cout"}, 64'(co),   64'(exp_c));
      chk({tag, "_ovf"},  64'(of),   64'(exp_o));
      @(posedge clk);
      #1;
   endtask

   task automatic basic_set(input int cfg, input logic [31:0] msk, input logic [31:0] sgn,
                            input int lat, input string tag);
      run_op(cfg, msk,        32'd1, 1'b0, 1'b0, 32'd0,          1'b1, 1'b0, lat, {tag, "_wrap"});
      run_op(cfg, sgn - 32'd1, 32'd1, 1'b0, 1'b0, sgn,           1'b0, 1'b1, lat, {tag, "_povf"});
      run_op(cfg, 32'h0F,     32'd1, 1'b1, 1'b0, 32'h11,         1'b0, 1'b0, lat, {tag, "_cin"});
      run_op(cfg, 32'd5,      32'd7, 1'b1, 1'b1, msk - 32'd1,    1'b0, 1'b0, lat, {tag, "_borrow"});
      run_op(cfg, sgn,        32'd1, 1'b0, 1'b1, sgn - 32'd1,    1'b1, 1'b1, lat, {tag, "_novf"});
   endtask

   initial begin
      bit   pat [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      int   sent, got, cyc, extra;
      logic acc, hold_pend;
      logic [31:0] held;

      rst_n = 1'b0;
      drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
      drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
      drive(2, 1'b0, '0, '0, 1'b0, 1'b0);
      i32.out_ready = 1'b1;
      i8.out_ready  = 1'b1;
      i16.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(i32.out_valid), 64'd0);
      chk("rst_s",         64'(i32.s),         64'd0);
      chk("rst_cout",      64'(i32.cout),      64'd0);
      chk("rst_ovf",       64'(i32.ovf),       64'd0);
      chk("rst_in_ready",  64'(i32.in_ready),  64'd1);
      chk("rst_ov8",       64'(i8.out_valid),  64'd0);
      chk("rst_ov16",      64'(i16.out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      basic_set(0, 32'hFFFF_FFFF, 32'h8000_0000, 4,  "n32");
      basic_set(1, 32'h0000_00FF, 32'h0000_0080, 1,  "n8");
      basic_set(2, 32'h0000_FFFF, 32'h0000_8000, 16, "n16");

      // Streaming with a repeating consumer stall pattern.
      sent = 0; got = 0; cyc = 0; hold_pend = 1'b0; held = '0;
      while (got < 20 && cyc < 400) begin
         @(negedge clk);
         i32.out_ready = pat[cyc % 5];
         if (sent < 20) drive(0, 1'b1, 32'(sent), 32'(2 * sent), 1'b0, 1'b0);
         else           drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
         #1;
         chk("stream_in_ready", 64'(i32.in_ready), 64'(!(i32.out_valid && !i32.out_ready)));
         if (hold_pend) chk("stream_hold_s", 64'(i32.s), 64'(held));
         hold_pend = i32.out_valid && !i32.out_ready;
         held      = i32.s;
         if (i32.out_valid && i32.out_ready) begin
            chk("stream_s", 64'(i32.s), 64'(3 * got));
            got++;
         end
         acc = i32.in_valid && i32.in_ready;
         @(posedge clk);
         if (acc) sent++;
         cyc++;
      end
      chk("stream_count", 64'(got), 64'd20);
      @(negedge clk);
      drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
      i32.out_ready = 1'b1;
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (i32.out_valid) extra++;
      end
      chk("stream_extra", 64'(extra), 64'd0);

      // Reset while tokens are in flight and one result is waiting.
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         drive(0, 1'b1, 32'(10 + t), 32'(t), 1'b0, 1'b0);
      end
      @(negedge clk);
      drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
      i32.out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_rst_out_valid", 64'(i32.out_valid), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(i32.out_valid), 64'd0);
      chk("mid_rst_in_ready",  64'(i32.in_ready),  64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      i32.out_ready = 1'b1;
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (i32.out_valid) extra++;
      end
      chk("post_rst_stale", 64'(extra), 64'd0);
      run_op(0, 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0, 4, "post_rst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
